// File: rtl/weave_sum_engine.sv
// Registered ADD/SUB/ACC/CLR engine with valid/ready handshakes and per-channel accumulators.
// Optional SATURATE_EN: clamps ADD/ACC to all-ones and SUB to zero instead of wrapping.
module weave_sum_engine #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [CH_W-1:0]  in_ch,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_err,
   output logic [15:0]      op_count
);

   localparam logic [1:0]    MODE_ADD = 2'd0;
   localparam logic [1:0]    MODE_SUB = 2'd1;
   localparam logic [1:0]    MODE_ACC = 2'd2;
   localparam logic [1:0]    MODE_CLR = 2'd3;
   localparam logic [CH_W:0] CH_LIM   = (CH_W+1)'(CHANNELS);

   logic             out_valid_q;
   logic [WIDTH-1:0] data_q, data_d;
   logic             carry_q, carry_d;
   logic             err_q, err_d;
   logic [15:0]      op_count_q;
   logic [WIDTH-1:0] acc_q [CHANNELS];

   logic             accept;
   logic             ch_ok;
   logic [WIDTH-1:0] acc_rd;
   logic [WIDTH:0]   sum, diff, acc_sum;
   logic             acc_we;
   logic [WIDTH-1:0] acc_wdata;

   // Upward overflow handling: clamp to all-ones when saturating, otherwise wrap.
   function automatic logic [WIDTH-1:0] clamp_up(input logic [WIDTH:0] s);
`ifdef SATURATE_EN
      return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
      return s[WIDTH-1:0];
`endif
   endfunction

   // Borrow handling: clamp to zero when saturating, otherwise wrap.
   function automatic logic [WIDTH-1:0] clamp_dn(input logic [WIDTH:0] d);
`ifdef SATURATE_EN
      return d[WIDTH] ? {WIDTH{1'b0}} : d[WIDTH-1:0];
`else
      return d[WIDTH-1:0];
`endif
   endfunction

   assign in_ready = !out_valid_q || out_ready;

   // Result and accumulator-write computation for the request on the inputs.
   always_comb begin
      accept = in_valid && in_ready;
      ch_ok  = {1'b0, in_ch} < CH_LIM;
      if (ch_ok) begin
         acc_rd = acc_q[in_ch];
      end else begin
         acc_rd = {WIDTH{1'b0}};
      end
      sum       = {1'b0, in_a} + {1'b0, in_b};
      diff      = {1'b0, in_a} - {1'b0, in_b};
      acc_sum   = {1'b0, acc_rd} + {1'b0, in_a};
      data_d    = {WIDTH{1'b0}};
      carry_d   = 1'b0;
      err_d     = 1'b0;
      acc_we    = 1'b0;
      acc_wdata = {WIDTH{1'b0}};
      case (in_mode)
         MODE_ADD: begin
            data_d  = clamp_up(sum);
            carry_d = sum[WIDTH];
         end
         MODE_SUB: begin
            data_d  = clamp_dn(diff);
            carry_d = diff[WIDTH];
         end
         MODE_ACC: begin
            if (ch_ok) begin
               data_d    = clamp_up(acc_sum);
               carry_d   = acc_sum[WIDTH];
               acc_we    = accept;
               acc_wdata = clamp_up(acc_sum);
            end else begin
               err_d = 1'b1;
            end
         end
         MODE_CLR: begin
            if (ch_ok) begin
               data_d = acc_rd;
               acc_we = accept;
            end else begin
               err_d = 1'b1;
            end
         end
         default: begin
            err_d = 1'b0;
         end
      endcase
   end

   // Output register, op counter and accumulator bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         data_q      <= {WIDTH{1'b0}};
         carry_q     <= 1'b0;
         err_q       <= 1'b0;
         op_count_q  <= 16'd0;
         for (int i = 0; i < CHANNELS; i++) begin
            acc_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            data_q      <= data_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            op_count_q  <= op_count_q + 16'd1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (acc_we) begin
            acc_q[in_ch] <= acc_wdata;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = data_q;
   assign out_carry = carry_q;
   assign out_err   = err_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_weave_sum_engine.sv
// Directed bench for weave_sum_engine (CHANNELS=3): behavioural model checked every cycle
// plus hand-computed literal expectations.
module tb_weave_sum_engine;

   localparam int W    = 8;
   localparam int NCH  = 3;
   localparam int CHW  = 2;
   localparam int MAXV = (1 << W) - 1;
`ifdef SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [1:0]     in_mode;
   logic [CHW-1:0] in_ch;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic           out_carry;
   logic           out_err;
   logic [15:0]    op_count;

   int n_vec = 0;
   int n_err = 0;

   weave_sum_engine #(.WIDTH(W), .CHANNELS(NCH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_carry(out_carry), .out_err(out_err), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model state
   int ev, ed, ec, ee, eop;
   int macc [NCH];
   int m_take, m_data, m_carry, m_err, m_we, m_wval, m_s, m_ch;

   always_comb begin
      m_take  = int'(in_valid && (ev == 0 || out_ready));
      m_data  = 0;
      m_carry = 0;
      m_err   = 0;
      m_we    = 0;
      m_wval  = 0;
      m_s     = 0;
      m_ch    = int'(in_ch);
      case (in_mode)
         2'd0: begin
            m_s     = int'(in_a) + int'(in_b);
            m_carry = int'(m_s > MAXV);
            m_data  = (m_carry != 0) ? (SAT ? MAXV : m_s - (MAXV + 1)) : m_s;
         end
         2'd1: begin
            m_carry = int'(in_a < in_b);
            m_data  = (m_carry != 0) ? (SAT ? 0 : int'(in_a) - int'(in_b) + MAXV + 1)
                                     : int'(in_a) - int'(in_b);
         end
         2'd2: begin
            if (m_ch >= NCH) begin
               m_err = 1;
            end else begin
               m_s     = macc[m_ch] + int'(in_a);
               m_carry = int'(m_s > MAXV);
               m_data  = (m_carry != 0) ? (SAT ? MAXV : m_s - (MAXV + 1)) : m_s;
               m_we    = 1;
               m_wval  = m_data;
            end
         end
         default: begin
            if (m_ch >= NCH) begin
               m_err = 1;
            end else begin
               m_data = macc[m_ch];
               m_we   = 1;
               m_wval = 0;
            end
         end
      endcase
   end

   // Model state advance
   always @(posedge clk) begin
      if (rst) begin
         ev <= 0; ed <= 0; ec <= 0; ee <= 0; eop <= 0;
         for (int i = 0; i < NCH; i++) macc[i] <= 0;
      end else if (m_take != 0) begin
         ev <= 1; ed <= m_data; ec <= m_carry; ee <= m_err;
         eop <= (eop + 1) % 65536;
         if (m_we != 0) macc[m_ch] <= m_wval;
      end else if (out_ready) begin
         ev <= 0;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("m_out_valid", 32'(out_valid), 32'(ev));
      chk("m_op_count", 32'(op_count), 32'(eop));
      chk("m_in_ready", 32'(in_ready), 32'(ev == 0 || out_ready));
      if (ev != 0) begin
         chk("m_out_data", 32'(out_data), 32'(ed));
         chk("m_out_carry", 32'(out_carry), 32'(ec));
         chk("m_out_err", 32'(out_err), 32'(ee));
      end
   end

   task automatic cyc(input logic v, input logic [1:0] m, input logic [CHW-1:0] ch,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
      in_valid  = v;
      in_mode   = m;
      in_ch     = ch;
      in_a      = a;
      in_b      = b;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_ch = '0;
      in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_carry", 32'(out_carry), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);
      chk("rst_opcnt", 32'(op_count), 32'd0);
      rst = 1'b0;
      #1;
      chk("rdy_after_rst", 32'(in_ready), 32'd1);

      cyc(1'b1, 2'd0, 2'd0, 8'h7F, 8'h01, 1'b1);
      chk("add_7f_valid", 32'(out_valid), 32'd1);
      chk("add_7f_data", 32'(out_data), 32'h80);
      chk("add_7f_carry", 32'(out_carry), 32'd0);
      chk("add_7f_opcnt", 32'(op_count), 32'd1);

      cyc(1'b1, 2'd0, 2'd0, 8'hFF, 8'h02, 1'b1);
      chk("add_ff_data", 32'(out_data), SAT ? 32'hFF : 32'h01);
      chk("add_ff_carry", 32'(out_carry), 32'd1);

      cyc(1'b1, 2'd1, 2'd0, 8'h03, 8'h05, 1'b1);
      chk("sub_data", 32'(out_data), SAT ? 32'h00 : 32'hFE);
      chk("sub_carry", 32'(out_carry), 32'd1);

      cyc(1'b1, 2'd2, 2'd2, 8'h10, 8'h00, 1'b1);
      chk("acc1_data", 32'(out_data), 32'h10);
      cyc(1'b1, 2'd2, 2'd2, 8'h10, 8'h00, 1'b1);
      chk("acc2_data", 32'(out_data), 32'h20);
      cyc(1'b1, 2'd2, 2'd2, 8'h10, 8'h00, 1'b1);
      chk("acc3_data", 32'(out_data), 32'h30);
      cyc(1'b1, 2'd3, 2'd2, 8'h00, 8'h00, 1'b1);
      chk("clr_data", 32'(out_data), 32'h30);
      chk("clr_carry", 32'(out_carry), 32'd0);
      cyc(1'b1, 2'd2, 2'd2, 8'h01, 8'h00, 1'b1);
      chk("acc_post_clr", 32'(out_data), 32'h01);

      cyc(1'b1, 2'd0, 2'd0, 8'h11, 8'h22, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 2'd1, 2'd0, 8'h50, 8'h10, 1'b0);
         chk("stall_ready", 32'(in_ready), 32'd0);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data", 32'(out_data), 32'h33);
      end
      cyc(1'b1, 2'd1, 2'd0, 8'h50, 8'h10, 1'b1);
      chk("xfer_accept_data", 32'(out_data), 32'h40);
      chk("xfer_accept_opcnt", 32'(op_count), 32'd10);

      cyc(1'b1, 2'd2, 2'd3, 8'h44, 8'h00, 1'b1);
      chk("err_acc_err", 32'(out_err), 32'd1);
      chk("err_acc_data", 32'(out_data), 32'd0);
      cyc(1'b1, 2'd3, 2'd3, 8'h00, 8'h00, 1'b1);
      chk("err_clr_err", 32'(out_err), 32'd1);
      chk("err_clr_carry", 32'(out_carry), 32'd0);
      cyc(1'b0, 2'd0, 2'd1, 8'hAA, 8'h55, 1'b1);
      chk("drain_valid", 32'(out_valid), 32'd0);

      cyc(1'b1, 2'd2, 2'd0, 8'h05, 8'h00, 1'b0);
      rst = 1'b1;
      cyc(1'b1, 2'd2, 2'd1, 8'h09, 8'h00, 1'b0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_opcnt", 32'(op_count), 32'd0);
      rst = 1'b0;
      cyc(1'b1, 2'd2, 2'd2, 8'h01, 8'h00, 1'b1);
      chk("midrst_acc2", 32'(out_data), 32'h01);
      cyc(1'b1, 2'd2, 2'd0, 8'h00, 8'h00, 1'b1);
      chk("midrst_acc0", 32'(out_data), 32'h00);
      cyc(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1);
      cyc(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
